// File: rtl/ttt_move_if.sv
// Request/status bundle between the player input logic and ttt_move_ctrl.
interface ttt_move_if;
    logic       new_game;
    logic       x_req;
    logic [1:0] x_row;
    logic [1:0] x_col;
    logic       o_req;
    logic [1:0] o_row;
    logic [1:0] o_col;
    logic       x_ack;
    logic       o_ack;
    logic       illegal;
    logic [8:0] pos_x;
    logic [8:0] pos_o;
    logic       turn;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output new_game, x_req, x_row, x_col, o_req, o_row, o_col,
        input  x_ack, o_ack, illegal, pos_x, pos_o, turn, game_over, winner
    );
    modport slave (
        input  new_game, x_req, x_row, x_col, o_req, o_row, o_col,
        output x_ack, o_ack, illegal, pos_x, pos_o, turn, game_over, winner
    );
endinterface

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move sequencer: turn arbitration, move validation, board scoring.
// Optional move timer enabled by defining TTT_TIMEOUT_EN.
module ttt_move_ctrl #(
    parameter bit FIRST_O        = 1'b0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic      clock,
    input  logic      reset,
    ttt_move_if.slave bus
);
    typedef enum logic [2:0] {TURN_X, TURN_O, CHECK, WIN, DRAW} state_e;
    localparam state_e START = FIRST_O ? TURN_O : TURN_X;

    function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
        return 4'd3 * (4'd3 - {2'b00, c}) + (4'd3 - {2'b00, r});
    endfunction

    function automatic logic has_line(input logic [8:0] p);
        return ((p & 9'h1C0) == 9'h1C0) || ((p & 9'h038) == 9'h038) ||
               ((p & 9'h007) == 9'h007) || ((p & 9'h124) == 9'h124) ||
               ((p & 9'h092) == 9'h092) || ((p & 9'h049) == 9'h049) ||
               ((p & 9'h111) == 9'h111) || ((p & 9'h054) == 9'h054);
    endfunction

    state_e     state_q, state_d;
    logic [8:0] pos_x_q, pos_x_d, pos_o_q, pos_o_d;
    logic       mover_q, mover_d;
    logic       x_arm_q, x_arm_d, o_arm_q, o_arm_d;
    logic       x_ack_q, x_ack_d, o_ack_q, o_ack_d, illegal_q, illegal_d;
    logic       turn_q, turn_d, over_q, over_d;
    logic [1:0] winner_q, winner_d;

    logic       in_turn, act_o, act_req, coord_ok, accept, reject, expire;
    logic [1:0] act_row, act_col;
    logic [3:0] act_idx;
    logic [8:0] act_bit, mover_pos;
    logic       mover_win, board_full;

    assign in_turn    = (state_q == TURN_X) || (state_q == TURN_O);
    assign act_o      = (state_q == TURN_O);
    // arm bits force a drop-and-reraise of req between a player's moves
    assign act_req    = act_o ? (bus.o_req && o_arm_q) : (bus.x_req && x_arm_q);
    assign act_row    = act_o ? bus.o_row : bus.x_row;
    assign act_col    = act_o ? bus.o_col : bus.x_col;
    assign coord_ok   = (act_row != 2'd0) && (act_col != 2'd0);
    assign act_idx    = cell_idx(act_row, act_col);
    assign act_bit    = coord_ok ? (9'd1 << act_idx) : 9'd0;
    assign accept     = in_turn && act_req && coord_ok && ((act_bit & (pos_x_q | pos_o_q)) == 9'd0);
    assign reject     = in_turn && act_req && !accept;
    assign mover_pos  = mover_q ? pos_o_q : pos_x_q;
    assign mover_win  = has_line(mover_pos);
    assign board_full = ((pos_x_q | pos_o_q) == 9'h1FF);

`ifdef TTT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmr_q, tmr_d;

    assign expire = in_turn && !accept && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmr_d = tmr_q;
        if (accept || expire || bus.new_game) tmr_d = '0;
        else if (in_turn)                     tmr_d = tmr_q + TW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) tmr_q <= '0;
        else       tmr_q <= tmr_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign expire     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= START;
            pos_x_q   <= '0;
            pos_o_q   <= '0;
            mover_q   <= 1'b0;
            x_arm_q   <= 1'b1;
            o_arm_q   <= 1'b1;
            x_ack_q   <= 1'b0;
            o_ack_q   <= 1'b0;
            illegal_q <= 1'b0;
            turn_q    <= FIRST_O;
            over_q    <= 1'b0;
            winner_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_o_q   <= pos_o_d;
            mover_q   <= mover_d;
            x_arm_q   <= x_arm_d;
            o_arm_q   <= o_arm_d;
            x_ack_q   <= x_ack_d;
            o_ack_q   <= o_ack_d;
            illegal_q <= illegal_d;
            turn_q    <= turn_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_o_d = pos_o_q;
        mover_d = mover_q;
        x_arm_d = x_arm_q || !bus.x_req;
        o_arm_d = o_arm_q || !bus.o_req;
        case (state_q)
            TURN_X, TURN_O: begin
                if (accept) begin
                    if (act_o) begin
                        pos_o_d = pos_o_q | act_bit;
                        o_arm_d = 1'b0;
                    end else begin
                        pos_x_d = pos_x_q | act_bit;
                        x_arm_d = 1'b0;
                    end
                    mover_d = act_o;
                    state_d = CHECK;
                end else if (expire) begin
                    state_d = act_o ? TURN_X : TURN_O;
                end
            end
            CHECK: begin
                if (mover_win)       state_d = WIN;
                else if (board_full) state_d = DRAW;
                else                 state_d = mover_q ? TURN_X : TURN_O;
            end
            default: ;
        endcase
        if (bus.new_game) begin
            state_d = START;
            pos_x_d = '0;
            pos_o_d = '0;
            mover_d = 1'b0;
        end
    end

    always_comb begin
        x_ack_d   = accept && !act_o;
        o_ack_d   = accept && act_o;
        illegal_d = reject || expire;
        turn_d    = turn_q;
        over_d    = over_q;
        winner_d  = winner_q;
        if (expire) turn_d = !act_o;
        if (state_q == CHECK) begin
            if (mover_win) begin
                over_d   = 1'b1;
                winner_d = mover_q ? 2'b10 : 2'b01;
            end else if (board_full) begin
                over_d   = 1'b1;
                winner_d = 2'b11;
            end else begin
                turn_d = !mover_q;
            end
        end
        if (bus.new_game) begin
            x_ack_d   = 1'b0;
            o_ack_d   = 1'b0;
            illegal_d = 1'b0;
            turn_d    = FIRST_O;
            over_d    = 1'b0;
            winner_d  = 2'b00;
        end
    end

    assign bus.x_ack     = x_ack_q;
    assign bus.o_ack     = o_ack_q;
    assign bus.illegal   = illegal_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_o     = pos_o_q;
    assign bus.turn      = turn_q;
    assign bus.game_over = over_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: vector table, directed corner sequences, random games vs a board model.
module tb_ttt_move_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clock = ~clock;

    ttt_move_if bx();
    ttt_move_if bo();

    ttt_move_ctrl #(.FIRST_O(1'b0), .TIMEOUT_CYCLES(8)) dut   (.clock(clock), .reset(reset), .bus(bx));
    ttt_move_ctrl #(.FIRST_O(1'b1), .TIMEOUT_CYCLES(8)) dut_o (.clock(clock), .reset(reset), .bus(bo));

`ifdef TTT_TIMEOUT_EN
    localparam int TK_LIM = 4;
`else
    localparam int TK_LIM = 1000;
`endif

    typedef struct {
        bit         xq, oq;
        logic [1:0] xr, xc, orw, oc;
        bit         e_xack, e_oack, e_ill;
        logic [8:0] e_px, e_po;
        bit         e_turn;
        logic [1:0] e_win;
    } vec_t;
    vec_t tbl[9];

    // board model: 0 empty, 1 X, 2 O
    int         m_cell[9];
    bit         m_turn;
    logic [1:0] m_win;
    int         tk;
    int         lines[8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                                '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] a, input logic [1:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chk9(input string nm, input logic [8:0] a, input logic [8:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic int idx_of(int r, int c);
        return 3 * (3 - c) + (3 - r);
    endfunction

    function automatic logic [8:0] occ(int who);
        logic [8:0] v = '0;
        for (int i = 0; i < 9; i++) if (m_cell[i] == who) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit owns_line(int who);
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who && m_cell[lines[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit full();
        for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 1'b0;
        m_win  = 2'b00;
        tk     = 0;
    endtask

    task automatic drive(input bit px, input bit po, input int xr, input int xc, input int orw, input int oc);
        bx.x_req = px;
        bx.x_row = 2'(xr);
        bx.x_col = 2'(xc);
        bx.o_req = po;
        bx.o_row = 2'(orw);
        bx.o_col = 2'(oc);
    endtask

    task automatic check_cleared(input string nm);
        chk9({nm, "_pos_x"}, bx.pos_x, 9'h000);
        chk9({nm, "_pos_o"}, bx.pos_o, 9'h000);
        chk1({nm, "_turn"}, bx.turn, 1'b0);
        chk2({nm, "_winner"}, bx.winner, 2'b00);
        chk1({nm, "_over"}, bx.game_over, 1'b0);
        chk1({nm, "_turn_firsto"}, bo.turn, 1'b1);
    endtask

    task automatic new_game_seq(input bit with_req);
        drive(with_req, with_req, 1, 1, 1, 1);
        bx.new_game = 1'b1;
        bo.new_game = 1'b1;
        tick();
        bx.new_game = 1'b0;
        bo.new_game = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        check_cleared("newgame");
        chk1("newgame_x_ack", bx.x_ack, 1'b0);
        chk1("newgame_o_ack", bx.o_ack, 1'b0);
        chk1("newgame_illegal", bx.illegal, 1'b0);
    endtask

    // one request cycle followed by one idle cycle, checked against the model
    task automatic move(input bit px, input bit po, input int xr, input int xc, input int orw, input int oc);
        bit areq, ok, acc;
        int r, c;
        areq = m_turn ? po : px;
        r    = m_turn ? orw : xr;
        c    = m_turn ? oc : xc;
        ok   = (r != 0) && (c != 0);
        if (ok) ok = (m_cell[idx_of(r, c)] == 0);
        acc  = (m_win == 2'b00) && areq && ok;
        drive(px, po, xr, xc, orw, oc);
        tick();
        chk1("x_ack", bx.x_ack, acc && !m_turn);
        chk1("o_ack", bx.o_ack, acc && m_turn);
        chk1("illegal", bx.illegal, (m_win == 2'b00) && areq && !ok);
        chk1("turn_hold", bx.turn, m_turn);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        if (acc) begin
            m_cell[idx_of(r, c)] = m_turn ? 2 : 1;
            if (owns_line(m_turn ? 2 : 1)) m_win = m_turn ? 2'b10 : 2'b01;
            else if (full())               m_win = 2'b11;
            else                           m_turn = !m_turn;
            tk = 0;
        end else begin
            tk += 2;
        end
        chk9("pos_x", bx.pos_x, occ(1));
        chk9("pos_o", bx.pos_o, occ(2));
        chk1("turn", bx.turn, m_turn);
        chk2("winner", bx.winner, m_win);
        chk1("game_over", bx.game_over, m_win != 2'b00);
    endtask

    task automatic play(input int idx);
        int r, c;
        r = 3 - idx % 3;
        c = 3 - idx / 3;
        if (m_turn) move(0, 1, 0, 0, r, c);
        else        move(1, 0, r, c, 0, 0);
    endtask

    task automatic rand_move();
        int q[$];
        int r, c, r2, c2, sel, pick;
        bit px, po;
        for (int i = 0; i < 9; i++) if (m_cell[i] == 0) q.push_back(i);
        if ($urandom_range(0, 1) == 1 && q.size() > 0) begin
            pick = q[$urandom_range(0, q.size() - 1)];
            r = 3 - pick % 3;
            c = 3 - pick / 3;
        end else begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
        end
        r2  = $urandom_range(0, 3);
        c2  = $urandom_range(0, 3);
        sel = $urandom_range(0, 9);
        px  = (sel < 7) ? !m_turn : (sel == 7) ? m_turn : 1'b1;
        po  = (sel < 7) ? m_turn  : (sel == 7) ? !m_turn : 1'b1;
        if (m_turn) move(px, po, r2, c2, r, c);
        else        move(px, po, r, c, r2, c2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1);
    end

    initial begin
        bit prev_turn;
        //            xq    oq    xr    xc    orw   oc    xack  oack  ill   px      po      turn  win
        tbl[0] = '{1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000, 1'b0, 2'b00};
        tbl[1] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 2'b00};
        tbl[2] = '{1'b1, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 9'h100, 9'h000, 1'b1, 2'b00};
        tbl[3] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 9'h100, 9'h000, 1'b1, 2'b00};
        tbl[4] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 9'h100, 9'h020, 1'b0, 2'b00};
        tbl[5] = '{1'b1, 1'b1, 2'd2, 2'd2, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 9'h110, 9'h020, 1'b1, 2'b00};
        tbl[6] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 9'h110, 9'h024, 1'b0, 2'b00};
        tbl[7] = '{1'b1, 1'b0, 2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 9'h111, 9'h024, 1'b0, 2'b01};
        tbl[8] = '{1'b1, 1'b0, 2'd3, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 9'h111, 9'h024, 1'b0, 2'b01};

        reset       = 1'b1;
        bx.new_game = 1'b0;
        bo.new_game = 1'b0;
        bo.x_req = 1'b0; bo.x_row = 2'd0; bo.x_col = 2'd0;
        bo.o_req = 1'b0; bo.o_row = 2'd0; bo.o_col = 2'd0;
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        tick();
        tick();
        check_cleared("reset");
        chk1("reset_x_ack", bx.x_ack, 1'b0);
        chk1("reset_illegal", bx.illegal, 1'b0);
        reset = 1'b0;

        prev_turn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bx.x_req = tbl[i].xq;  bx.x_row = tbl[i].xr;  bx.x_col = tbl[i].xc;
            bx.o_req = tbl[i].oq;  bx.o_row = tbl[i].orw; bx.o_col = tbl[i].oc;
            tick();
            chk1("tbl_x_ack", bx.x_ack, tbl[i].e_xack);
            chk1("tbl_o_ack", bx.o_ack, tbl[i].e_oack);
            chk1("tbl_illegal", bx.illegal, tbl[i].e_ill);
            chk1("tbl_turn_hold", bx.turn, prev_turn);
            drive(0, 0, 0, 0, 0, 0);
            tick();
            chk9("tbl_pos_x", bx.pos_x, tbl[i].e_px);
            chk9("tbl_pos_o", bx.pos_o, tbl[i].e_po);
            chk1("tbl_turn", bx.turn, tbl[i].e_turn);
            chk2("tbl_winner", bx.winner, tbl[i].e_win);
            chk1("tbl_over", bx.game_over, tbl[i].e_win != 2'b00);
            prev_turn = tbl[i].e_turn;
        end

        // new_game in WIN with both reqs high
        new_game_seq(1'b1);

        // held req is not re-accepted on the player's next turn
        drive(1, 0, 1, 1, 0, 0);
        tick();
        chk1("hold_first_ack", bx.x_ack, 1'b1);
        tick();
        chk1("hold_turn_o", bx.turn, 1'b1);
        drive(1, 1, 1, 1, 1, 2);
        tick();
        chk1("hold_o_ack", bx.o_ack, 1'b1);
        drive(1, 0, 2, 2, 0, 0);
        tick();
        chk1("hold_turn_x", bx.turn, 1'b0);
        tick();
        chk1("hold_no_reack", bx.x_ack, 1'b0);
        chk1("hold_no_illegal", bx.illegal, 1'b0);
        drive(0, 0, 2, 2, 0, 0);
        tick();
        drive(1, 0, 2, 2, 0, 0);
        tick();
        chk1("hold_reraise_ack", bx.x_ack, 1'b1);
        chk9("hold_pos_x", bx.pos_x, 9'h110);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        new_game_seq(1'b0);

        // draw: X 8,6,5,1,0 / O 7,4,3,2
        play(8); play(7); play(6); play(4); play(5); play(3); play(1); play(2); play(0);
        chk2("draw_winner", bx.winner, 2'b11);
        chk1("draw_over", bx.game_over, 1'b1);
        new_game_seq(1'b0);

        // ninth move completes a line: win beats draw
        play(8); play(7); play(3); play(6); play(1); play(5); play(2); play(4); play(0);
        chk2("win9_winner", bx.winner, 2'b01);
        chk9("win9_full", bx.pos_x | bx.pos_o, 9'h1FF);
        new_game_seq(1'b0);

        // reset asserted while in CHECK
        drive(1, 0, 1, 1, 0, 0);
        tick();
        chk1("rstchk_ack", bx.x_ack, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("rstchk");
        model_clear();

`ifdef TTT_TIMEOUT_EN
        new_game_seq(1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk1("tmo_early_illegal", bx.illegal, 1'b0);
            chk1("tmo_early_turn", bx.turn, 1'b0);
        end
        tick();
        chk1("tmo_illegal", bx.illegal, 1'b1);
        chk1("tmo_turn", bx.turn, 1'b1);
        chk9("tmo_pos_x", bx.pos_x, 9'h000);
        chk1("tmo_no_ack", bx.x_ack, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk1("tmo_o_wait_illegal", bx.illegal, 1'b0);
        end
        drive(0, 1, 0, 0, 1, 1);
        tick();
        chk1("tmo_expiry_ack", bx.o_ack, 1'b1);
        chk1("tmo_expiry_no_illegal", bx.illegal, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk9("tmo_expiry_pos_o", bx.pos_o, 9'h100);
        chk1("tmo_expiry_turn", bx.turn, 1'b0);
`endif

        new_game_seq(1'b0);
        for (int n = 0; n < 400; n++) begin
            if (m_win != 2'b00) begin
                rand_move();
                new_game_seq($urandom_range(0, 1) == 1);
            end else if (tk >= TK_LIM || $urandom_range(0, 59) == 0) begin
                new_game_seq($urandom_range(0, 1) == 1);
            end else begin
                rand_move();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
